// File: rtl/tetris_op_commit.sv
// -----------------------------------------------------------------------------
// tetris_op_commit
//
// Sequential owner of the Tetris game state. It holds the committed 20x20
// field, the active 4x4 block with its X/Y position, the score and the
// game-over flag. Operation requests from the input controller are handed to
// an external combinational predictor (via predOp and the current state
// outputs). The predictor's results are sampled one cycle later and the
// operation is committed, rejected or turned into a lock.
//
// Optional feature: define GRAVITY_EN to add a gravity tick counter. It issues
// an internal DOWN operation after DROP_TICKS idle cycles. With GRAVITY_EN
// undefined the block only moves on external requests.
//
// Ports:
//   clk, resetn      clock and asynchronous active-low reset
//   opValid, opCode  operation request (0=LEFT 1=RIGHT 2=ROTATE 3=DOWN)
//   opReady          high only while idle and able to accept a request
//   opDone           one-cycle pulse when an operation completes
//   opAccepted       result of the last completed operation (1=committed)
//   predOp           operation under evaluation; 4 = spawn placement check
//   field            committed field, bit y*20+x
//   block            active block, bit r*4+c
//   blockX, blockY   active block position
//   pred*            results from the combinational predictor
//   score            saturating count of cleared lines
//   gameOver         set when a freshly spawned block does not fit
// -----------------------------------------------------------------------------
module tetris_op_commit #(
  parameter int          SPAWN_X    = 8,
  parameter int          SCORE_W    = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          DROP_TICKS = 25000000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               opValid,
  input  logic [1:0]         opCode,
  output logic               opReady,
  output logic               opDone,
  output logic               opAccepted,
  output logic [2:0]         predOp,
  output logic [399:0]       field,
  output logic [15:0]        block,
  output logic [4:0]         blockX,
  output logic [4:0]         blockY,
  input  logic               predOpOK,
  input  logic               predBottomTouch,
  input  logic [15:0]        predNewBlock,
  input  logic [4:0]         predNewX,
  input  logic [4:0]         predNewY,
  input  logic [399:0]       predNewField,
  input  logic [2:0]         predLines,
  output logic [SCORE_W-1:0] score,
  output logic               gameOver
);

  typedef enum logic [2:0] {
    SPAWN     = 3'd0,
    SPAWN_CHK = 3'd1,
    IDLE      = 3'd2,
    EVAL      = 3'd3,
    OVER      = 3'd4
  } stateE;

  localparam logic [4:0]  SPAWN_COL = 5'(SPAWN_X);
  localparam logic [2:0]  OP_DOWN   = 3'd3;
  localparam logic [2:0]  OP_NOP    = 3'd4;
  localparam logic [24:0] DROP_TERM = 25'(DROP_TICKS - 1);

  // Piece table indexed by LFSR mod 7: I, O, T, S, Z, J, L (bit r*4+c).
  function automatic logic [15:0] pieceFor(input logic [15:0] lfsrVal);
    logic [15:0] sel;
    logic [15:0] shape;
    sel = lfsrVal % 16'd7;
    case (sel)
      16'd0:   shape = 16'h00F0; // I: row 1, columns 0..3
      16'd1:   shape = 16'h0066; // O: rows 0..1, columns 1..2
      16'd2:   shape = 16'h0027; // T: row 0 columns 0..2, stem at (1,1)
      16'd3:   shape = 16'h0036; // S
      16'd4:   shape = 16'h0063; // Z
      16'd5:   shape = 16'h0071; // J
      16'd6:   shape = 16'h0074; // L
      default: shape = 16'h0000;
    endcase
    return shape;
  endfunction

  // 16-bit Fibonacci LFSR step, taps 16,14,13,11, shifting toward the MSB.
  function automatic logic [15:0] lfsrAdvance(input logic [15:0] cur);
    logic fb;
    fb = cur[15] ^ cur[13] ^ cur[12] ^ cur[10];
    return {cur[14:0], fb};
  endfunction

  stateE               stateR;
  stateE               stateNext;
  logic [399:0]        fieldR;
  logic [399:0]        fieldNext;
  logic [15:0]         blockR;
  logic [15:0]         blockNext;
  logic [4:0]          blockXR;
  logic [4:0]          blockXNext;
  logic [4:0]          blockYR;
  logic [4:0]          blockYNext;
  logic [SCORE_W-1:0]  scoreR;
  logic [SCORE_W-1:0]  scoreNext;
  logic [SCORE_W:0]    scoreSum;
  logic [SCORE_W-1:0]  scoreSat;
  logic                overR;
  logic                overNext;
  logic                doneR;
  logic                doneNext;
  logic                accR;
  logic                accNext;
  logic                readyR;
  logic                readyNext;
  logic [2:0]          predOpR;
  logic [2:0]          predOpNext;
  logic [15:0]         lfsrR;
  logic [15:0]         lfsrNext;
  logic                gravityFire;

  // Saturating score update: predLines zero-extended, carry-out forces all-ones.
  assign scoreSum = {1'b0, scoreR} + {{(SCORE_W - 2){1'b0}}, predLines};
  assign scoreSat = scoreSum[SCORE_W] ? {SCORE_W{1'b1}} : scoreSum[SCORE_W-1:0];

`ifdef GRAVITY_EN
  logic [24:0] tickR;
  logic        lockNow;

  assign lockNow     = (stateR == EVAL) && (predOpR == OP_DOWN) && predBottomTouch;
  assign gravityFire = (stateR == IDLE) && (tickR == DROP_TERM) && !opValid;

  // Gravity tick counter: counts idle cycles, holds at terminal while an
  // external request takes the slot, restarts after firing or on a lock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tickR <= 25'd0;
    end else if (lockNow) begin
      tickR <= 25'd0;
    end else if (stateR == IDLE) begin
      if (tickR == DROP_TERM) begin
        if (!opValid) begin
          tickR <= 25'd0;
        end else begin
          tickR <= tickR;
        end
      end else begin
        tickR <= tickR + 25'd1;
      end
    end else begin
      tickR <= tickR;
    end
  end
`else
  logic [24:0] unusedDropTerm;

  assign unusedDropTerm = DROP_TERM;
  assign gravityFire    = 1'b0;
`endif

  // Next-state and next-datapath decode for the operation FSM.
  always_comb begin
    stateNext  = stateR;
    fieldNext  = fieldR;
    blockNext  = blockR;
    blockXNext = blockXR;
    blockYNext = blockYR;
    scoreNext  = scoreR;
    overNext   = overR;
    doneNext   = 1'b0;
    accNext    = accR;
    predOpNext = predOpR;
    lfsrNext   = lfsrR;
    case (stateR)
      SPAWN: begin
        blockNext  = pieceFor(lfsrR);
        blockXNext = SPAWN_COL;
        blockYNext = 5'd0;
        predOpNext = OP_NOP;
        lfsrNext   = lfsrAdvance(lfsrR);
        stateNext  = SPAWN_CHK;
      end
      SPAWN_CHK: begin
        // The predictor evaluates the new block in place under the NOP op.
        if (predOpOK) begin
          stateNext = IDLE;
        end else begin
          stateNext = OVER;
          overNext  = 1'b1;
        end
      end
      IDLE: begin
        if (opValid) begin
          predOpNext = {1'b0, opCode};
          stateNext  = EVAL;
        end else if (gravityFire) begin
          predOpNext = OP_DOWN;
          stateNext  = EVAL;
        end else begin
          stateNext = IDLE;
        end
      end
      EVAL: begin
        doneNext = 1'b1;
        // A DOWN that touches bottom locks even if the move itself is legal.
        if ((predOpR == OP_DOWN) && predBottomTouch) begin
          fieldNext = predNewField;
          scoreNext = scoreSat;
          accNext   = 1'b1;
          stateNext = SPAWN;
        end else if (predOpOK) begin
          blockNext  = predNewBlock;
          blockXNext = predNewX;
          blockYNext = predNewY;
          accNext    = 1'b1;
          stateNext  = IDLE;
        end else begin
          accNext   = 1'b0;
          stateNext = IDLE;
        end
      end
      OVER: begin
        stateNext = OVER;
        overNext  = 1'b1;
      end
      default: begin
        stateNext = SPAWN;
      end
    endcase
    readyNext = (stateNext == IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stateR <= SPAWN;
    end else begin
      stateR <= stateNext;
    end
  end

  // Game-state and handshake registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fieldR  <= 400'd0;
      blockR  <= 16'd0;
      blockXR <= SPAWN_COL;
      blockYR <= 5'd0;
      scoreR  <= {SCORE_W{1'b0}};
      overR   <= 1'b0;
      doneR   <= 1'b0;
      accR    <= 1'b0;
      readyR  <= 1'b0;
      predOpR <= OP_NOP;
      lfsrR   <= LFSR_SEED;
    end else begin
      fieldR  <= fieldNext;
      blockR  <= blockNext;
      blockXR <= blockXNext;
      blockYR <= blockYNext;
      scoreR  <= scoreNext;
      overR   <= overNext;
      doneR   <= doneNext;
      accR    <= accNext;
      readyR  <= readyNext;
      predOpR <= predOpNext;
      lfsrR   <= lfsrNext;
    end
  end

  assign opReady    = readyR;
  assign opDone     = doneR;
  assign opAccepted = accR;
  assign predOp     = predOpR;
  assign field      = fieldR;
  assign block      = blockR;
  assign blockX     = blockXR;
  assign blockY     = blockYR;
  assign score      = scoreR;
  assign gameOver   = overR;

endmodule

// File: tb/tb_tetris_op_commit.sv
// Self-checking bench for tetris_op_commit (default build, GRAVITY_EN undefined).
// The bench plays the predictor with random results and keeps an abstract
// game model (field, block, position, score, piece generator) to derive
// the expected outcome of every operation.
module tb_tetris_op_commit;

  localparam int          SW   = 8;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [SW-1:0] SMAX = {SW{1'b1}};

  logic           clk;
  logic           resetn;
  logic           opValid;
  logic [1:0]     opCode;
  logic           opReady;
  logic           opDone;
  logic           opAccepted;
  logic [2:0]     predOp;
  logic [399:0]   field;
  logic [15:0]    block;
  logic [4:0]     blockX;
  logic [4:0]     blockY;
  logic           predOpOK;
  logic           predBottomTouch;
  logic [15:0]    predNewBlock;
  logic [4:0]     predNewX;
  logic [4:0]     predNewY;
  logic [399:0]   predNewField;
  logic [2:0]     predLines;
  logic [SW-1:0]  score;
  logic           gameOver;

  tetris_op_commit #(
    .SPAWN_X(8), .SCORE_W(SW), .LFSR_SEED(SEED), .DROP_TICKS(4)
  ) dut (
    .clk(clk), .resetn(resetn), .opValid(opValid), .opCode(opCode),
    .opReady(opReady), .opDone(opDone), .opAccepted(opAccepted), .predOp(predOp),
    .field(field), .block(block), .blockX(blockX), .blockY(blockY),
    .predOpOK(predOpOK), .predBottomTouch(predBottomTouch), .predNewBlock(predNewBlock),
    .predNewX(predNewX), .predNewY(predNewY), .predNewField(predNewField),
    .predLines(predLines), .score(score), .gameOver(gameOver)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model of the game
  logic [399:0]  mField;
  logic [15:0]   mBlock;
  logic [4:0]    mX;
  logic [4:0]    mY;
  logic [SW-1:0] mScore;
  logic [15:0]   mLfsr;

  // Observations captured by the stimulus helpers
  logic          obsTimeout;
  logic [2:0]    obsEvalPredOp;
  logic          obsEvalReady;
  logic          obsEvalDone;
  logic          obsDone;
  logic          obsAcc;
  logic          obsReady;
  logic [399:0]  obsField;
  logic [15:0]   obsBlock;
  logic [4:0]    obsX;
  logic [4:0]    obsY;
  logic [SW-1:0] obsScore;
  logic [15:0]   spBlock;
  logic [4:0]    spX;
  logic [4:0]    spY;
  logic [2:0]    spPredOp;
  logic          spReady;
  logic          chkReady;
  logic          chkOver;

  // Tetromino cells as (row, col) pairs: I, O, T, S, Z, J, L
  int pieceCells [7][8] = '{
    '{1,0, 1,1, 1,2, 1,3},
    '{0,1, 0,2, 1,1, 1,2},
    '{0,0, 0,1, 0,2, 1,1},
    '{0,1, 0,2, 1,0, 1,1},
    '{0,0, 0,1, 1,1, 1,2},
    '{0,0, 1,0, 1,1, 1,2},
    '{0,2, 1,0, 1,1, 1,2}
  };

  function automatic logic [15:0] ref_piece(input logic [15:0] gen);
    int idx;
    logic [15:0] m;
    idx = int'(gen) % 7;
    m = 16'd0;
    for (int k = 0; k < 4; k++) m[pieceCells[idx][2*k]*4 + pieceCells[idx][2*k+1]] = 1'b1;
    return m;
  endfunction

  function automatic logic [15:0] ref_lfsr(input logic [15:0] x);
    int taps [4];
    logic fb;
    taps = '{16, 14, 13, 11};
    fb = 1'b0;
    for (int k = 0; k < 4; k++) fb = fb ^ x[taps[k]-1];
    return {x[14:0], fb};
  endfunction

  function automatic logic [SW-1:0] ref_score(input logic [SW-1:0] s, input logic [2:0] l);
    int sum;
    sum = int'(s) + int'(l);
    if (sum > int'(SMAX)) sum = int'(SMAX);
    return sum[SW-1:0];
  endfunction

  function automatic logic [399:0] rand_field();
    logic [399:0] f;
    for (int k = 0; k < 400; k++) f[k] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation with the given predictor answers; capture outputs
  // during evaluation and right after completion.
  task automatic run_op(input logic [1:0] code, input logic ok, input logic touch,
                        input logic [15:0] nb, input logic [4:0] nx, input logic [4:0] ny,
                        input logic [399:0] nf, input logic [2:0] lines);
    obsTimeout = 1'b0;
    for (int i = 0; i < 20 && opReady !== 1'b1; i++) step();
    if (opReady !== 1'b1) obsTimeout = 1'b1;
    opValid = 1'b1; opCode = code;
    predOpOK = ok; predBottomTouch = touch; predNewBlock = nb;
    predNewX = nx; predNewY = ny; predNewField = nf; predLines = lines;
    step();
    obsEvalPredOp = predOp; obsEvalReady = opReady; obsEvalDone = opDone;
    // A request presented while busy must be ignored.
    opCode = 2'($urandom_range(0, 3));
    step();
    opValid = 1'b0;
    obsDone = opDone; obsAcc = opAccepted; obsReady = opReady;
    obsField = field; obsBlock = block; obsX = blockX; obsY = blockY; obsScore = score;
  endtask

  // Follow a lock through SPAWN and SPAWN_CHK with the given placement answer.
  task automatic run_spawn(input logic ok);
    predOpOK = ok;
    step();
    spBlock = block; spX = blockX; spY = blockY; spPredOp = predOp; spReady = opReady;
    step();
    chkReady = opReady; chkOver = gameOver;
  endtask

  task automatic test_reset();
    resetn = 1'b0; opValid = 1'b0; opCode = 2'd0;
    predOpOK = 1'b1; predBottomTouch = 1'b0; predNewBlock = 16'd0;
    predNewX = 5'd0; predNewY = 5'd0; predNewField = 400'd0; predLines = 3'd0;
    step(); step();
    checks++; if (field !== 400'd0) begin failures++; $display("FAIL reset_field: got %h want 0", field); end
    checks++; if (block !== 16'd0) begin failures++; $display("FAIL reset_block: got %h want 0", block); end
    checks++; if (blockX !== 5'd8 || blockY !== 5'd0) begin failures++; $display("FAIL reset_pos: got %0d,%0d want 8,0", blockX, blockY); end
    checks++; if (score !== 8'd0 || gameOver !== 1'b0) begin failures++; $display("FAIL reset_score_over: got %h,%b want 0,0", score, gameOver); end
    checks++; if (opDone !== 1'b0 || opAccepted !== 1'b0 || opReady !== 1'b0) begin failures++; $display("FAIL reset_handshake: got done=%b acc=%b rdy=%b want 0,0,0", opDone, opAccepted, opReady); end
    checks++; if (predOp !== 3'd4) begin failures++; $display("FAIL reset_predop: got %0d want 4", predOp); end
    resetn = 1'b1;
    step();
    checks++; if (block !== ref_piece(SEED) || blockX !== 5'd8 || blockY !== 5'd0) begin failures++; $display("FAIL spawn_first: got %h @%0d,%0d want %h @8,0", block, blockX, blockY, ref_piece(SEED)); end
    checks++; if (predOp !== 3'd4 || opReady !== 1'b0) begin failures++; $display("FAIL spawn_first_nop: got op=%0d rdy=%b want 4,0", predOp, opReady); end
    step();
    checks++; if (opReady !== 1'b1 || gameOver !== 1'b0) begin failures++; $display("FAIL spawn_first_ready: got rdy=%b over=%b want 1,0", opReady, gameOver); end
    mField = 400'd0; mBlock = ref_piece(SEED); mX = 5'd8; mY = 5'd0; mScore = '0;
    mLfsr = ref_lfsr(SEED);
  endtask

  task automatic test_move_right();
    logic [15:0] nb;
    nb = 16'($urandom);
    run_op(2'd1, 1'b1, 1'b0, nb, 5'd9, mY, rand_field(), 3'd3);
    checks++; if (obsTimeout !== 1'b0) begin failures++; $display("FAIL right_timeout: got %b want 0", obsTimeout); end
    checks++; if (obsEvalPredOp !== 3'd1 || obsEvalDone !== 1'b0 || obsEvalReady !== 1'b0) begin failures++; $display("FAIL right_eval: got op=%0d done=%b rdy=%b want 1,0,0", obsEvalPredOp, obsEvalDone, obsEvalReady); end
    checks++; if (obsDone !== 1'b1 || obsAcc !== 1'b1 || obsReady !== 1'b1) begin failures++; $display("FAIL right_done: got done=%b acc=%b rdy=%b want 1,1,1", obsDone, obsAcc, obsReady); end
    checks++; if (obsX !== 5'd9 || obsBlock !== nb || obsField !== mField) begin failures++; $display("FAIL right_state: got x=%0d blk=%h want 9,%h", obsX, obsBlock, nb); end
    mX = 5'd9; mBlock = nb;
    step();
    checks++; if (opDone !== 1'b0 || opAccepted !== 1'b1) begin failures++; $display("FAIL right_pulse: got done=%b acc=%b want 0,1", opDone, opAccepted); end
  endtask

  task automatic test_rotate_reject();
    run_op(2'd2, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 5'($urandom), 5'($urandom), rand_field(), 3'd4);
    checks++; if (obsEvalPredOp !== 3'd2) begin failures++; $display("FAIL rot_predop: got %0d want 2", obsEvalPredOp); end
    checks++; if (obsDone !== 1'b1 || obsAcc !== 1'b0 || obsReady !== 1'b1) begin failures++; $display("FAIL rot_done: got done=%b acc=%b rdy=%b want 1,0,1", obsDone, obsAcc, obsReady); end
    checks++; if (obsBlock !== mBlock || obsX !== mX || obsY !== mY || obsField !== mField || obsScore !== mScore) begin failures++; $display("FAIL rot_unchanged: got blk=%h x=%0d y=%0d want %h,%0d,%0d", obsBlock, obsX, obsY, mBlock, mX, mY); end
  endtask

  task automatic test_lock();
    logic [399:0] pat;
    pat = rand_field();
    run_op(2'd3, 1'($urandom_range(0, 1)), 1'b1, 16'($urandom), 5'($urandom), 5'($urandom), pat, 3'd2);
    checks++; if (obsField !== pat) begin failures++; $display("FAIL lock_field: got %h want %h", obsField, pat); end
    checks++; if (obsScore !== ref_score(mScore, 3'd2) || obsDone !== 1'b1 || obsAcc !== 1'b1 || obsReady !== 1'b0) begin failures++; $display("FAIL lock_score: got sc=%0d done=%b acc=%b rdy=%b want %0d,1,1,0", obsScore, obsDone, obsAcc, obsReady, ref_score(mScore, 3'd2)); end
    checks++; if (obsBlock !== mBlock || obsX !== mX || obsY !== mY) begin failures++; $display("FAIL lock_block_kept: got %h want %h", obsBlock, mBlock); end
    mField = pat; mScore = ref_score(mScore, 3'd2);
    run_spawn(1'b1);
    checks++; if (spBlock !== ref_piece(mLfsr) || spX !== 5'd8 || spY !== 5'd0 || spPredOp !== 3'd4 || spReady !== 1'b0) begin failures++; $display("FAIL lock_spawn: got %h @%0d,%0d op=%0d want %h @8,0 op=4", spBlock, spX, spY, spPredOp, ref_piece(mLfsr)); end
    checks++; if (chkReady !== 1'b1 || chkOver !== 1'b0) begin failures++; $display("FAIL lock_spawn_chk: got rdy=%b over=%b want 1,0", chkReady, chkOver); end
    mBlock = ref_piece(mLfsr); mX = 5'd8; mY = 5'd0; mLfsr = ref_lfsr(mLfsr);
  endtask

  task automatic test_random();
    logic [1:0] code; logic ok; logic touch; logic [15:0] nb; logic [4:0] nx; logic [4:0] ny;
    logic [399:0] nf; logic [2:0] lines; logic expLock; logic expAcc;
    for (int it = 0; it < 60; it++) begin
      code = 2'($urandom_range(0, 3)); ok = 1'($urandom_range(0, 1));
      touch = ($urandom_range(0, 3) == 0); nb = 16'($urandom);
      nx = 5'($urandom); ny = 5'($urandom); nf = rand_field(); lines = 3'($urandom_range(0, 4));
      run_op(code, ok, touch, nb, nx, ny, nf, lines);
      expLock = (code == 2'd3) && touch;
      expAcc = expLock || ok;
      if (expLock) begin
        mField = nf; mScore = ref_score(mScore, lines);
      end else if (ok) begin
        mBlock = nb; mX = nx; mY = ny;
      end
      checks++; if (obsTimeout !== 1'b0 || obsEvalPredOp !== {1'b0, code}) begin failures++; $display("FAIL rnd_eval[%0d]: got to=%b op=%0d want 0,%0d", it, obsTimeout, obsEvalPredOp, code); end
      checks++; if (obsDone !== 1'b1 || obsAcc !== expAcc || obsReady !== !expLock) begin failures++; $display("FAIL rnd_done[%0d]: got acc=%b rdy=%b want %b,%b", it, obsAcc, obsReady, expAcc, !expLock); end
      checks++; if (obsBlock !== mBlock || obsX !== mX || obsY !== mY) begin failures++; $display("FAIL rnd_block[%0d]: got %h @%0d,%0d want %h @%0d,%0d", it, obsBlock, obsX, obsY, mBlock, mX, mY); end
      checks++; if (obsField !== mField || obsScore !== mScore) begin failures++; $display("FAIL rnd_field_score[%0d]: got sc=%0d want %0d", it, obsScore, mScore); end
      if (expLock) begin
        run_spawn(1'b1);
        checks++; if (spBlock !== ref_piece(mLfsr) || spX !== 5'd8 || spY !== 5'd0 || chkReady !== 1'b1) begin failures++; $display("FAIL rnd_spawn[%0d]: got %h rdy=%b want %h,1", it, spBlock, chkReady, ref_piece(mLfsr)); end
        mBlock = ref_piece(mLfsr); mX = 5'd8; mY = 5'd0; mLfsr = ref_lfsr(mLfsr);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] nx;
    nx = mX;
    opValid = 1'b1; opCode = 2'd0; predOpOK = 1'b1; predBottomTouch = 1'b0;
    predNewBlock = mBlock; predNewY = mY;
    for (int i = 1; i <= 6; i++) begin
      if (i % 2 == 1) begin
        nx = 5'($urandom); predNewX = nx;
      end
      step();
      checks++; if (opDone !== (i % 2 == 0) || opReady !== (i % 2 == 0)) begin failures++; $display("FAIL b2b_cycle[%0d]: got done=%b rdy=%b want %b", i, opDone, opReady, (i % 2 == 0)); end
      if (i % 2 == 0) begin
        mX = nx;
        checks++; if (blockX !== mX || opAccepted !== 1'b1) begin failures++; $display("FAIL b2b_x[%0d]: got %0d want %0d", i, blockX, mX); end
      end
    end
    opValid = 1'b0;
    step(); step();
  endtask

  task automatic test_saturate();
    logic [2:0] lines;
    for (int it = 0; it < 200 && mScore != (SMAX - 1'b1); it++) begin
      lines = ((SMAX - 1'b1 - mScore) > 4) ? 3'd4 : 3'(SMAX - 1'b1 - mScore);
      run_op(2'd3, 1'b1, 1'b1, 16'd0, 5'd0, 5'd0, mField, lines);
      mScore = ref_score(mScore, lines);
      checks++; if (obsScore !== mScore) begin failures++; $display("FAIL sat_climb[%0d]: got %0d want %0d", it, obsScore, mScore); end
      run_spawn(1'b1);
      mBlock = ref_piece(mLfsr); mX = 5'd8; mY = 5'd0; mLfsr = ref_lfsr(mLfsr);
    end
    run_op(2'd3, 1'b1, 1'b1, 16'd0, 5'd0, 5'd0, mField, 3'd4);
    checks++; if (obsScore !== SMAX) begin failures++; $display("FAIL sat_top: got %h want %h", obsScore, SMAX); end
    mScore = SMAX;
    run_spawn(1'b1);
    checks++; if (spBlock !== ref_piece(mLfsr)) begin failures++; $display("FAIL sat_spawn: got %h want %h", spBlock, ref_piece(mLfsr)); end
    mBlock = ref_piece(mLfsr); mX = 5'd8; mY = 5'd0; mLfsr = ref_lfsr(mLfsr);
    run_op(2'd3, 1'b0, 1'b1, 16'd0, 5'd0, 5'd0, mField, 3'd3);
    checks++; if (obsScore !== SMAX) begin failures++; $display("FAIL sat_hold: got %h want %h", obsScore, SMAX); end
  endtask

  task automatic test_game_over();
    int bad;
    logic [15:0] blk;
    logic [399:0] fld;
    run_spawn(1'b0);
    checks++; if (spBlock !== ref_piece(mLfsr) || chkOver !== 1'b1 || chkReady !== 1'b0) begin failures++; $display("FAIL over_enter: got over=%b rdy=%b want 1,0", chkOver, chkReady); end
    blk = block; fld = field;
    bad = 0;
    predOpOK = 1'b1; predBottomTouch = 1'b1; predNewField = rand_field(); predLines = 3'd4;
    for (int i = 0; i < 100; i++) begin
      opValid = 1'b1; opCode = 2'($urandom_range(0, 3));
      step();
      if (opReady !== 1'b0 || gameOver !== 1'b1 || opDone !== 1'b0 || block !== blk || field !== fld || score !== mScore) bad++;
    end
    opValid = 1'b0;
    checks++; if (bad !== 0) begin failures++; $display("FAIL over_frozen: got %0d bad cycles want 0", bad); end
    resetn = 1'b0;
    #1;
    checks++; if (gameOver !== 1'b0 || score !== '0 || field !== 400'd0) begin failures++; $display("FAIL over_reset: got over=%b sc=%0d want 0,0", gameOver, score); end
    step();
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_rotate_reject();
    test_lock();
    test_random();
    test_back_to_back();
    test_saturate();
    test_game_over();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tetris_op_commit.md
Name: tetris_op_commit

Overview:
- Sequential owner of the Tetris game state: the 20x20 field, the active 4x4 block, its X/Y position, the score and game-over.
- Accepts move/rotate/drop requests from the input controller and drives the current state to the external combinational predictor stage.
- Samples the predictor's results and commits or rejects each operation, locks pieces, spawns new ones and detects game over.
- Sits between the key/input controller and the predictor/VGA field renderer.

Parameters:
- SPAWN_X, 8, column where each new block's top-left cell is placed (Y is always 0).
- SCORE_W, 16, width of the score register.
- LFSR_SEED, 16'hACE1, nonzero reset seed of the piece-select LFSR.
- DROP_TICKS, 25000000, gravity period in clk cycles (used only with GRAVITY_EN).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- opValid  in  1  operation request
- opCode  in  2  operation: 0=LEFT, 1=RIGHT, 2=ROTATE, 3=DOWN
- opReady  out  1  high only in IDLE
- opDone  out  1  one-cycle pulse when an operation completes
- opAccepted  out  1  valid with opDone: 1=committed, 0=rejected
- predOp  out  3  operation under evaluation: opCode, or 4=NOP spawn check
- field  out  400  committed field, bit y*20+x
- block  out  16  active block, bit r*4+c
- blockX  out  5  active block column
- blockY  out  5  active block row
- predOpOK  in  1  predictor: candidate placement legal
- predBottomTouch  in  1  predictor: candidate rests on floor or stack
- predNewBlock  in  16  predictor: candidate block
- predNewX  in  5  predictor: candidate X
- predNewY  in  5  predictor: candidate Y
- predNewField  in  400  predictor: field with block merged and lines cleared
- predLines  in  3  predictor: lines cleared by the merge (0-4)
- score  out  SCORE_W  accumulated cleared lines
- gameOver  out  1  game ended

Behaviour:
- Reset (async, resetn low):
  - field=0, block=0, blockX=SPAWN_X, blockY=0, score=0, gameOver=0.
  - opDone=0, opAccepted=0, predOp=4, LFSR=LFSR_SEED.
  - state=SPAWN.
- Reset mid-operation aborts it; no partial commit.
- FSM states: SPAWN, SPAWN_CHK, IDLE, EVAL, OVER.
- SPAWN (1 cycle):
  - block = piece table[LFSR mod 7]; table entries are I,O,T,S,Z,J,L in fixed 4x4 encodings.
  - blockX=SPAWN_X, blockY=0, predOp=4, advance LFSR.
  - Next state: SPAWN_CHK.
- SPAWN_CHK: sample predOpOK. 0 -> OVER. 1 -> IDLE.
- IDLE:
  - opReady=1.
  - opValid&&opReady: latch predOp=opCode, go EVAL.
  - opValid while opReady=0 is ignored; the requester holds it.
- EVAL (exactly 1 cycle; the predictor is combinational from field/block/blockX/blockY/predOp). At the end of the cycle, first matching rule wins:
  1. predOp==DOWN && predBottomTouch:
     - lock: field<=predNewField, score<=score+predLines (saturate at all-ones).
     - opDone=1, opAccepted=1, next SPAWN.
  2. predOpOK:
     - block<=predNewBlock, blockX<=predNewX, blockY<=predNewY.
     - opDone=1, opAccepted=1, next IDLE.
  3. Otherwise:
     - state unchanged, opDone=1, opAccepted=0, next IDLE.
- Latency: request accepted at cycle N, state and opDone visible at N+2; next accept possible at N+2.
- OVER: gameOver=1, opReady=0, no further changes; only resetn exits.
- opDone and opAccepted are registered; opAccepted holds until the next opDone.
- Score arithmetic: zero-extend predLines to SCORE_W. If the sum overflows, score=all-ones.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances once per SPAWN only.

Optional Feature:
- Macro GRAVITY_EN.
- Defined:
  - A 25-bit tick counter increments in IDLE; it is cleared on every lock and on reset.
  - At DROP_TICKS-1 with opValid low, an internal DOWN op is issued exactly as if requested.
  - If opValid is high the same cycle, the external op wins and the counter holds at terminal until the next IDLE.
- Not defined: no counter; blocks move only on external ops.

Test Plan:
- Reset then release, predOpOK=1: SPAWN->SPAWN_CHK->IDLE in 2 cycles; blockX=8, blockY=0, block=piece[LFSR_SEED mod 7], opReady=1 on cycle 3.
- IDLE, opValid with opCode=1, predOpOK=1, predNewX=9: predOp=1; 2 cycles later blockX=9, opDone=1, opAccepted=1.
- opCode=2 with predOpOK=0: block/X/Y unchanged, opDone=1, opAccepted=0, back in IDLE.
- opCode=3, predBottomTouch=1, predLines=2, predNewField=pattern P: field=P, score=2, then SPAWN.
- Score at 16'hFFFE, lock with predLines=4: score=16'hFFFF.
- SPAWN_CHK with predOpOK=0: gameOver=1, opReady stays 0 for 100 cycles; resetn low clears gameOver immediately.
- GRAVITY_EN with DROP_TICKS=4: no input, DOWN issued every 4 idle cycles; opValid on the terminal tick takes priority.
